// File: rtl/steer_delay_line.sv
// -----------------------------------------------------------------------------
// steer_delay_line
//
// Ping-steered delay line. An accepted ping injects a single '1' into a
// DEPTH-stage shift register that advances once per prescaler tick. Each of
// the CHANS output channels fires a one-cycle pulse when the '1' passes its
// programmable tap. Taps are loaded via a serial shadow register, validated
// at commit time, parked in a pending register and copied to the active taps
// only while the block is idle.
//
// Ports:
//   ISYSCLK  in  1      system clock
//   RSTALLD  in  1      synchronous active-high reset
//   REGDATA  in  1      serial configuration data bit
//   REGCLKS  in  1      shift REGDATA into the shadow register this cycle
//   REGLTCH  in  1      commit the shadow frame (wins over REGCLKS)
//   DIVSETV  in  DIVW   tick period minus one
//   PINGREQ  in  1      ping launch request (honoured only when idle)
//   PINGACK  out 1      one-cycle request accept
//   BUSYOUT  out 1      ping in flight
//   CHANOUT  out CHANS  one-cycle per-channel fire pulses
//   CFGERRS  out 1      sticky bad-commit flag
// -----------------------------------------------------------------------------
module steer_delay_line #(
  parameter int DEPTH = 32,
  parameter int CHANS = 4,
  parameter int TAPW  = 5,
  parameter int DIVW  = 8
) (
  input  logic             ISYSCLK,
  input  logic             RSTALLD,
  input  logic             REGDATA,
  input  logic             REGCLKS,
  input  logic             REGLTCH,
  input  logic [DIVW-1:0]  DIVSETV,
  input  logic             PINGREQ,
  output logic             PINGACK,
  output logic             BUSYOUT,
  output logic [CHANS-1:0] CHANOUT,
  output logic             CFGERRS
);

  localparam int NBITS = CHANS * TAPW;
  // Counter saturates one past a full frame so over-long frames stay invalid.
  localparam int CNTW  = $clog2(NBITS + 2);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_FLIGHT = 2'd2;

  // Reset tap image: channel c taps stage (c mod DEPTH).
  function automatic logic [NBITS-1:0] default_taps();
    logic [NBITS-1:0] v;
    v = '0;
    for (int c = 0; c < CHANS; c++) begin
      v[c*TAPW +: TAPW] = TAPW'(c % DEPTH);
    end
    return v;
  endfunction

  // A frame is usable only if every tap field addresses an existing stage.
  function automatic logic fields_ok(input logic [NBITS-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int c = 0; c < CHANS; c++) begin
      if (32'(v[c*TAPW +: TAPW]) >= 32'(DEPTH)) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  logic [1:0]       state_q,    state_d;
  logic [DIVW-1:0]  presc_q,    presc_d;
  logic [TAPW-1:0]  flt_q,      flt_d;
  logic [DEPTH-1:0] sr_q,       sr_d;
  logic [NBITS-1:0] shadow_q,   shadow_d;
  logic [CNTW-1:0]  bitcnt_q,   bitcnt_d;
  logic [NBITS-1:0] pend_q,     pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [NBITS-1:0] taps_q,     taps_d;
  logic             ack_q,      ack_d;
  logic             busy_q,     busy_d;
  logic [CHANS-1:0] chan_q,     chan_d;
  logic             err_q,      err_d;

  logic             tick;
  logic [DEPTH-1:0] sr_shift;

  // Prescaler tick and the shifted delay-line image used on a tick.
  always_comb begin
    tick     = (state_q != ST_IDLE) && (presc_q == DIVSETV);
    sr_shift = {sr_q[DEPTH-2:0], (state_q == ST_LAUNCH)};
  end

  // Ping FSM, prescaler, flight counter, delay line and channel pulses.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    flt_d   = flt_q;
    sr_d    = sr_q;
    ack_d   = 1'b0;
    chan_d  = '0;

    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        flt_d   = '0;
        if (PINGREQ) begin
          state_d = ST_LAUNCH;
          ack_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        if (tick) begin
          state_d = ST_FLIGHT;
          sr_d    = sr_shift;
        end else begin
          state_d = ST_LAUNCH;
        end
      end
      ST_FLIGHT: begin
        if (tick) begin
          // LAUNCH already spent one tick, so DEPTH-1 more finish the flight.
          if (flt_q == TAPW'(DEPTH - 2)) begin
            state_d = ST_IDLE;
            flt_d   = '0;
            sr_d    = '0;
          end else begin
            flt_d = flt_q + TAPW'(1);
            sr_d  = sr_shift;
          end
        end else begin
          state_d = ST_FLIGHT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        presc_d = '0;
        flt_d   = '0;
        sr_d    = '0;
      end
    endcase

    if (state_q != ST_IDLE) begin
      // An out-of-reach DIVSETV lets the count roll over naturally.
      if (tick) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + DIVW'(1);
      end
    end else begin
      presc_d = '0;
    end

    // Pulses see the post-shift line even on the final tick that clears sr.
    for (int c = 0; c < CHANS; c++) begin
      chan_d[c] = tick & sr_shift[taps_q[c*TAPW +: TAPW]];
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Serial shadow loader, commit validation and pending-to-active tap copy.
  always_comb begin
    shadow_d   = shadow_q;
    bitcnt_d   = bitcnt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    err_d      = err_q;
    taps_d     = taps_q;

    // Copy only on an idle edge that does not launch, so a ping never sees
    // its taps change after acceptance.
    if ((state_q == ST_IDLE) && !PINGREQ && pend_vld_q) begin
      taps_d     = pend_q;
      pend_vld_d = 1'b0;
    end else begin
      taps_d = taps_q;
    end

    if (REGLTCH) begin
      bitcnt_d = '0;
      if ((bitcnt_q == CNTW'(NBITS)) && fields_ok(shadow_q)) begin
        pend_d     = shadow_q;
        pend_vld_d = 1'b1;
        err_d      = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (REGCLKS) begin
      shadow_d = {shadow_q[NBITS-2:0], REGDATA};
      if (bitcnt_q != CNTW'(NBITS + 1)) begin
        bitcnt_d = bitcnt_q + CNTW'(1);
      end else begin
        bitcnt_d = bitcnt_q;
      end
    end else begin
      shadow_d = shadow_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge ISYSCLK) begin
    if (RSTALLD) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      flt_q      <= '0;
      sr_q       <= '0;
      shadow_q   <= '0;
      bitcnt_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      taps_q     <= default_taps();
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      chan_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      flt_q      <= flt_d;
      sr_q       <= sr_d;
      shadow_q   <= shadow_d;
      bitcnt_q   <= bitcnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      taps_q     <= taps_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      chan_q     <= chan_d;
      err_q      <= err_d;
    end
  end

  assign PINGACK = ack_q;
  assign BUSYOUT = busy_q;
  assign CHANOUT = chan_q;
  assign CFGERRS = err_q;

endmodule

// File: tb/tb_steer_delay_line.sv
// -----------------------------------------------------------------------------
// tb_steer_delay_line
//
// Scoreboard bench. The driver advances a behavioural model one cycle at a
// time: an accepted ping pushes its expected pulse cycles
// (2+D+tap*(D+1) after acceptance) into a time-ordered queue and records its
// busy window of (D+1)*DEPTH cycles. A separate monitor pops and compares on
// the falling edge. A second instance with DEPTH=20 covers out-of-range tap
// fields.
// -----------------------------------------------------------------------------
module tb_steer_delay_line;
  localparam int DEPTH = 32;
  localparam int CHANS = 4;
  localparam int TAPW  = 5;
  localparam int DIVW  = 8;
  localparam int NB    = CHANS * TAPW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, rdata, rclks, rltch, preq;
  logic [DIVW-1:0]  divset;
  logic             ack, busy, err;
  logic [CHANS-1:0] chan;

  steer_delay_line #(.DEPTH(DEPTH), .CHANS(CHANS), .TAPW(TAPW), .DIVW(DIVW)) dut (
    .ISYSCLK(clk), .RSTALLD(rst), .REGDATA(rdata), .REGCLKS(rclks),
    .REGLTCH(rltch), .DIVSETV(divset), .PINGREQ(preq), .PINGACK(ack),
    .BUSYOUT(busy), .CHANOUT(chan), .CFGERRS(err)
  );

  logic             rst20, rdata20, rclks20, rltch20;
  logic             ack20, busy20, err20;
  logic [CHANS-1:0] chan20;

  steer_delay_line #(.DEPTH(20), .CHANS(CHANS), .TAPW(TAPW), .DIVW(DIVW)) dut20 (
    .ISYSCLK(clk), .RSTALLD(rst20), .REGDATA(rdata20), .REGCLKS(rclks20),
    .REGLTCH(rltch20), .DIVSETV(8'd0), .PINGREQ(1'b0), .PINGACK(ack20),
    .BUSYOUT(busy20), .CHANOUT(chan20), .CFGERRS(err20)
  );

  typedef struct {
    int             cyc;
    logic [CHANS-1:0] mask;
  } ev_t;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  bit  mon_en = 1'b0;

  ev_t exp_q[$];
  int  ack_at = -1;
  int  busy_s = -1;
  int  busy_e = -2;
  int  err_from = 0;
  bit  err_prev = 1'b0;
  bit  err_new = 1'b0;
  int  act_tap[CHANS];
  int  pend_tap[CHANS];
  bit  pend_v = 1'b0;
  bit  bits_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Compare helper shared by the monitor and the directed checks.
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_busy(int k);
    return (k >= busy_s) && (k <= busy_e);
  endfunction

  function automatic bit m_err(int k);
    return (k >= err_from) ? err_new : err_prev;
  endfunction

  // Add one expected pulse, merging channels that fire in the same cycle.
  task automatic add_event(int t, int c);
    ev_t e;
    int  i;
    for (i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc == t) begin
        exp_q[i].mask[c] = 1'b1;
        return;
      end
      if (exp_q[i].cyc > t) break;
    end
    e.cyc = t;
    e.mask = '0;
    e.mask[c] = 1'b1;
    exp_q.insert(i, e);
  endtask

  task automatic m_accept(int k);
    int d;
    d = int'(divset);
    ack_at = k + 1;
    busy_s = k + 1;
    busy_e = k + (d + 1) * DEPTH;
    for (int c = 0; c < CHANS; c++) add_event(k + 2 + d + act_tap[c] * (d + 1), c);
  endtask

  task automatic m_commit(int k);
    bit ok;
    int f[CHANS];
    ok = (bits_q.size() == NB);
    if (ok) begin
      for (int c = 0; c < CHANS; c++) begin
        f[c] = 0;
        for (int b = 0; b < TAPW; b++) f[c] = f[c] * 2 + int'(bits_q[(CHANS - 1 - c) * TAPW + b]);
        if (f[c] >= DEPTH) ok = 1'b0;
      end
    end
    err_prev = m_err(k);
    err_from = k + 1;
    if (ok) begin
      pend_tap = f;
      pend_v   = 1'b1;
      err_new  = 1'b0;
    end else begin
      err_new  = 1'b1;
    end
    bits_q.delete();
  endtask

  // Drive one cycle of stimulus and advance the model to match it.
  task automatic drive(bit r, bit req, bit ck, bit d, bit lt);
    int k;
    bit bz;
    k = cyc;
    bz = m_busy(k);
    rst = r; preq = req; rclks = ck; rdata = d; rltch = lt;
    if (r) begin
      if (busy_e > k) busy_e = k;
      if (ack_at > k) ack_at = -1;
      while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].cyc > k) exp_q.delete(exp_q.size() - 1);
      err_prev = m_err(k);
      err_new  = 1'b0;
      err_from = k + 1;
      for (int c = 0; c < CHANS; c++) act_tap[c] = c % DEPTH;
      pend_v = 1'b0;
      bits_q.delete();
    end else begin
      if (!bz && !req && pend_v) begin
        act_tap = pend_tap;
        pend_v  = 1'b0;
      end
      if (req && !bz) m_accept(k);
      if (lt) m_commit(k);
      else if (ck) bits_q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Shift the first nbits of a frame (ch3 field MSB first), then commit.
  task automatic send_frame(logic [NB-1:0] fr, int nbits);
    for (int i = 0; i < nbits; i++) drive(1'b0, 1'b0, 1'b1, fr[NB - 1 - i], 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic d20(bit r, bit ck, bit d, bit lt);
    rst20 = r; rclks20 = ck; rdata20 = d; rltch20 = lt;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every DUT output against the model each cycle.
  always @(negedge clk) begin
    logic [CHANS-1:0] em;
    if (mon_en) begin
      em = '0;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("chan_missed", 32'(exp_q[0].cyc), 32'(cyc));
        exp_q.delete(0);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        em = exp_q[0].mask;
        exp_q.delete(0);
      end
      if (em != '0 || chan != '0) chk("chanout", 32'(chan), 32'(em));
      if (ack !== 1'b0 || ack_at == cyc) chk("pingack", 32'(ack), 32'(ack_at == cyc));
      chk("busyout", 32'(busy), 32'(m_busy(cyc)));
      chk("cfgerrs", 32'(err), 32'(m_err(cyc)));
    end
  end

  initial begin
    bit             frame[$];
    bit             want_commit;
    bit             r, q, ck, dbit, lt;
    logic [NB-1:0]  fr;
    int             flen;

    rst = 1'b1; rdata = 1'b0; rclks = 1'b0; rltch = 1'b0; preq = 1'b0; divset = '0;
    rst20 = 1'b1; rdata20 = 1'b0; rclks20 = 1'b0; rltch20 = 1'b0;
    for (int c = 0; c < CHANS; c++) act_tap[c] = c;

    // DEPTH=20 instance: a field of 25 is rejected, in-range fields accepted.
    @(posedge clk);
    #1;
    d20(1'b1, 1'b0, 1'b0, 1'b0);
    chk("d20_reset_err", 32'(err20), 32'd0);
    fr = {5'd25, 5'd1, 5'd2, 5'd3};
    for (int i = 0; i < NB; i++) d20(1'b0, 1'b1, fr[NB - 1 - i], 1'b0);
    d20(1'b0, 1'b0, 1'b0, 1'b1);
    chk("d20_field25_err", 32'(err20), 32'd1);
    fr = {5'd19, 5'd0, 5'd5, 5'd10};
    for (int i = 0; i < NB; i++) d20(1'b0, 1'b1, fr[NB - 1 - i], 1'b0);
    d20(1'b0, 1'b0, 1'b0, 1'b1);
    chk("d20_valid_err", 32'(err20), 32'd0);
    chk("d20_chan_quiet", 32'(chan20), 32'd0);

    // Main instance reset; outputs are checked from the first post-reset cycle.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    chk("reset_chan", 32'(chan), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    idle(3);

    // Default taps, DIVSETV=0; a second request while busy is ignored.
    divset = 8'd0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(34);

    // Reset in cycle 10 of a flight, then request right after reset.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(9);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(36);

    // Taps {31,16,8,0} with DIVSETV=3: pulses 5/37/69/129 cycles out.
    send_frame({5'd31, 5'd16, 5'd8, 5'd0}, NB);
    idle(2);
    divset = 8'd3;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(135);

    // Short frame is rejected, then a full frame clears the flag.
    send_frame({5'd3, 5'd2, 5'd1, 5'd7}, NB - 1);
    idle(2);
    chk("short_frame_err", 32'(err), 32'd1);
    send_frame({5'd5, 5'd9, 5'd1, 5'd2}, NB);
    idle(2);
    chk("good_frame_err", 32'(err), 32'd0);
    divset = 8'd1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(70);

    // Commit during a flight: this ping keeps old taps, the next uses new.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    send_frame({5'd0, 5'd30, 5'd12, 5'd4}, NB);
    idle(50);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(70);

    // Randomized traffic: frames of varied length, pings, resets, DIVSETV.
    want_commit = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      r = ($urandom_range(0, 799) == 0);
      q = ($urandom_range(0, 24) == 0);
      ck = 1'b0; dbit = 1'b0; lt = 1'b0;
      if (!m_busy(cyc) && $urandom_range(0, 59) == 0) divset = DIVW'($urandom_range(0, 3));
      if (want_commit) begin
        lt = 1'b1;
        ck = 1'($urandom_range(0, 1));
        dbit = 1'($urandom_range(0, 1));
        want_commit = 1'b0;
      end else if (frame.size() > 0) begin
        if ($urandom_range(0, 1) == 1) begin
          ck = 1'b1;
          dbit = frame.pop_front();
          if (frame.size() == 0) want_commit = 1'b1;
        end
      end else if ($urandom_range(0, 39) == 0) begin
        flen = ($urandom_range(0, 3) == 0) ? $urandom_range(NB - 2, NB + 2) : NB;
        for (int i = 0; i < flen; i++) frame.push_back(1'($urandom_range(0, 1)));
      end
      drive(r, q, ck, dbit, lt);
    end

    idle(200);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/steer_delay_line.md
STEER_DELAY_LINE -- requirements
Module: steer_delay_line

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL take these parameters:
- DEPTH, 32, delay-line stages (>=2).
- CHANS, 4, number of steered output channels.
- TAPW, 5, tap-select width, equal to ceil(log2(DEPTH)).
- DIVW, 8, prescaler width.
REQ-003 The block SHALL have these ports:
- ISYSCLK  in   1           system clock.
- RSTALLD  in   1           synchronous active-high reset.
- REGDATA  in   1           serial configuration data bit.
- REGCLKS  in   1           single-cycle qualifier: shift REGDATA this cycle.
- REGLTCH  in   1           single-cycle commit strobe for the serial frame.
- DIVSETV  in   DIVW        tick period minus one.
- PINGREQ  in   1           ping launch request.
- PINGACK  out  1           one-cycle request accept.
- BUSYOUT  out  1           ping in flight.
- CHANOUT  out  CHANS       one-cycle per-channel fire pulses.
- CFGERRS  out  1           sticky bad-commit flag.

Function
REQ-004 The block SHALL use a three-state FSM:
- IDLE to LAUNCH on PINGREQ=1; PINGACK is high the following cycle.
- LAUNCH to FLIGHT on the first tick.
- FLIGHT to IDLE on its (DEPTH-1)th tick.
REQ-005 The block SHALL ignore PINGREQ outside IDLE, with no PINGACK.
REQ-006 BUSYOUT SHALL be 1 exactly while the state is LAUNCH or FLIGHT.
REQ-007 The prescaler counter SHALL behave as follows:
- Held at 0 in IDLE.
- Increments each cycle in LAUNCH/FLIGHT.
- tick=1 when count==DIVSETV, and count wraps to 0 on that cycle.
- DIVSETV=0 gives a tick every cycle.
- A value below the current count takes effect on the next wrap.
REQ-008 The delay line sr[0..DEPTH-1] SHALL shift up by one on each tick; sr[0] loads 1 on the LAUNCH tick and 0 otherwise.
REQ-009 sr SHALL be cleared on the transition into IDLE.
REQ-010 CHANOUT[c] SHALL be a registered output, set on a tick edge to the post-shift value of sr[tap[c]] and 0 on every other edge.
REQ-011 Timing SHALL follow from REQ-008/010: request sampled in cycle 0 gives CHANOUT[c] high in exactly cycle 2+D+tap[c]*(D+1), where D=DIVSETV.
REQ-012 The serial loader SHALL work as follows:
- Shadow register of CHANS*TAPW bits and a saturating bit counter.
- On REGCLKS=1, the shadow shifts left with REGDATA entering the LSB.
- The first bit of a frame lands in the MSB of the channel CHANS-1 field.
REQ-013 On REGLTCH=1, the commit SHALL be valid only if the bit count is exactly CHANS*TAPW and every field is <DEPTH:
- Valid: set the pending register (a later commit overwrites it) and clear CFGERRS.
- Invalid: set CFGERRS; the taps are unchanged.
- Either way: clear the bit counter.
REQ-014 If REGLTCH and REGCLKS are both 1 in one cycle, REGLTCH SHALL win and the REGCLKS bit is discarded.
REQ-015 Pending taps SHALL be copied to the active taps on the first edge where the state is IDLE and not leaving IDLE; a ping in flight always uses the taps active at its acceptance.

Reset
REQ-016 RSTALLD=1 SHALL drive the following state at the next edge, regardless of state:
- FSM=IDLE.
- Prescaler, flight counter, bit counter and sr all 0.
- Shadow and pending cleared.
- Active tap[c] = c mod DEPTH.
- PINGACK, BUSYOUT, CHANOUT and CFGERRS all 0.
REQ-017 Reset mid-flight SHALL suppress all remaining CHANOUT pulses; a PINGREQ in the first cycle after reset SHALL be accepted.

Verification
REQ-018 Default taps, DIVSETV=0, PINGREQ in cycle 0 -> PINGACK in cycle 1; CHANOUT[c] high only in cycle 2+c; BUSYOUT high in cycles 1-32, low in cycle 33.
REQ-019 Load taps {ch3..ch0} = {31,16,8,0}, commit, DIVSETV=3, ping in cycle 0 -> CHANOUT[0]/[1]/[2]/[3] fire in cycles 5/37/69/129 respectively.
REQ-020 Commit errors:
- 19 bits then REGLTCH -> CFGERRS=1, taps unchanged.
- Then 20 valid bits plus REGLTCH -> CFGERRS=0, new taps used.
- A field of 32 with DEPTH=32 is impossible in 5 bits, so also rerun with DEPTH=20 and a field of 25 -> CFGERRS=1.
REQ-021 Commit new taps during FLIGHT -> the current ping fires with the old taps; the next ping fires with the new taps.
REQ-022 PINGREQ during BUSYOUT -> no PINGACK and no extra pulses. RSTALLD in cycle 10 of REQ-018 -> from cycle 11 BUSYOUT=0 and CHANOUT=0; PINGREQ in cycle 11 -> PINGACK in cycle 12.
